// File: rtl/active_vertex_offset_fetch_if.sv
// Offset-memory bus between the active-vertex offset fetch stage and the CSR
// offset memory.
//   master : the fetch stage. It drives the read requests and takes the responses.
//   slave  : the memory. It accepts the requests and returns in-order responses.
// Signals:
//   offset_rd_addr   local vertex index to read
//   offset_rd_valid  read request valid
//   offset_rd_ready  memory accepts the request
//   offset_rsp_data  {roffset, loffset}, with loffset in the low bits
//   offset_rsp_valid response valid. Responses return in request order.
interface active_vertex_offset_fetch_if #(
  parameter int V_ID_WIDTH   = 20,
  parameter int OFFSET_WIDTH = 24
) ();
  logic [V_ID_WIDTH-1:0]     offset_rd_addr;
  logic                      offset_rd_valid;
  logic                      offset_rd_ready;
  logic [2*OFFSET_WIDTH-1:0] offset_rsp_data;
  logic                      offset_rsp_valid;

  modport master (
    output offset_rd_addr,
    output offset_rd_valid,
    input  offset_rd_ready,
    input  offset_rsp_data,
    input  offset_rsp_valid
  );

  modport slave (
    input  offset_rd_addr,
    input  offset_rd_valid,
    output offset_rd_ready,
    output offset_rsp_data,
    output offset_rsp_valid
  );
endinterface

// File: rtl/active_vertex_offset_fetch.sv
// Active-vertex offset fetch stage (one per core).
// The stage buffers the active vertex IDs that come from the active-vertex reader.
// For each vertex it issues one CSR offset read. Each result {v_id, loffset,
// roffset} goes to the edge-fetch stage, in arrival order. The upstream
// iteration-end marker is forwarded only after every vertex of the iteration has
// left the stage.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   active_v_id(_valid)      vertex stream from upstream
//   iteration_end(_valid)    upstream iteration-end level
//   stage_full               registered backpressure to upstream
//   mem                      offset-memory bus (master side)
//   next_stage_full          downstream backpressure
//   out_v_id/loffset/roffset result to the edge-fetch stage, qualified by out_valid
//   out_iteration_end(_valid) one-cycle iteration-end marker
//
// Optional feature: define ISOLATED_VTX_FILTER_EN to drop vertices whose
// roffset equals loffset (zero out-degree). Their tag and credit are still
// released.
//
// FIFO_DEPTH and MAX_OUTSTANDING must be powers of two. The pointers wrap
// naturally.
module active_vertex_offset_fetch #(
  parameter int V_ID_WIDTH      = 20,
  parameter int CORE_NUM_WIDTH  = 5,
  parameter int OFFSET_WIDTH    = 24,
  parameter int FIFO_DEPTH      = 16,
  parameter int FULL_MARGIN     = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [V_ID_WIDTH-1:0]   active_v_id,
  input  logic                    active_v_id_valid,
  input  logic                    iteration_end,
  input  logic                    iteration_end_valid,
  output logic                    stage_full,
  active_vertex_offset_fetch_if.master mem,
  input  logic                    next_stage_full,
  output logic [V_ID_WIDTH-1:0]   out_v_id,
  output logic [OFFSET_WIDTH-1:0] out_loffset,
  output logic [OFFSET_WIDTH-1:0] out_roffset,
  output logic                    out_valid,
  output logic                    out_iteration_end,
  output logic                    out_iteration_end_valid
);

  localparam int IN_AW    = $clog2(FIFO_DEPTH);
  localparam int IN_CW    = $clog2(FIFO_DEPTH + 1);
  localparam int TAG_AW   = $clog2(MAX_OUTSTANDING);
  localparam int TAG_CW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int CREDIT_W = TAG_CW + 1;

  typedef struct packed {
    logic [V_ID_WIDTH-1:0]   v_id;
    logic [OFFSET_WIDTH-1:0] loffset;
    logic [OFFSET_WIDTH-1:0] roffset;
  } result_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_EMIT,
    S_WAIT_CLR
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [V_ID_WIDTH-1:0] in_mem  [FIFO_DEPTH];
  logic [V_ID_WIDTH-1:0] tag_mem [MAX_OUTSTANDING];
  result_t               rb_mem  [MAX_OUTSTANDING];

  logic [IN_AW-1:0]  in_wr_ptr, in_rd_ptr;
  logic [IN_CW-1:0]  in_count, in_count_next;
  logic [TAG_AW-1:0] tag_wr_ptr, tag_rd_ptr;
  logic [TAG_CW-1:0] tag_count;
  logic [TAG_AW-1:0] rb_wr_ptr, rb_rd_ptr;
  logic [TAG_CW-1:0] rb_count;
  logic              overflow;

  state_t state, state_next;

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  logic                  in_full, in_empty, in_push, in_pop;
  logic [V_ID_WIDTH-1:0] in_head;
  logic [CREDIT_W-1:0]   credit_used;
  logic                  rsp_accept, rsp_keep, rsp_fwd;
  logic                  rb_empty, rb_push, rb_pop;
  logic                  out_allow, bypass, out_fire;
  result_t               rsp_entry, out_src;
  logic                  ie_level, drained, ie_pulse;

  assign in_full       = (in_count == IN_CW'(FIFO_DEPTH));
  assign in_empty      = (in_count == '0);
  assign in_push       = active_v_id_valid && !in_full;
  assign in_head       = in_mem[in_rd_ptr];
  assign in_count_next = in_count + IN_CW'(in_push) - IN_CW'(in_pop);

  // Responses already sitting in the buffer use up credit. This keeps the
  // in-flight reads plus the buffered results within the buffer depth, so a
  // response always has a slot.
  assign credit_used = CREDIT_W'(tag_count) + CREDIT_W'(rb_count);

  // The request stays stable while it is stalled. Nothing below can lower the
  // FIFO fill or raise credit_used without an accepted request.
  assign mem.offset_rd_valid = !in_empty
                             && (tag_count < TAG_CW'(MAX_OUTSTANDING))
                             && (credit_used < CREDIT_W'(MAX_OUTSTANDING));
  assign mem.offset_rd_addr  = mem.offset_rd_valid ? (in_head >> CORE_NUM_WIDTH) : '0;
  assign in_pop              = mem.offset_rd_valid && mem.offset_rd_ready;

  // A response with no tag is left over from before a reset. It is ignored.
  assign rsp_accept = mem.offset_rsp_valid && (tag_count != '0);
  assign rsp_entry  = {tag_mem[tag_rd_ptr],
                       mem.offset_rsp_data[OFFSET_WIDTH-1:0],
                       mem.offset_rsp_data[2*OFFSET_WIDTH-1:OFFSET_WIDTH]};

`ifdef ISOLATED_VTX_FILTER_EN
  assign rsp_keep = (rsp_entry.roffset != rsp_entry.loffset);
`else
  assign rsp_keep = 1'b1;
`endif

  assign rsp_fwd = rsp_accept && rsp_keep;

  // Output is held off while the marker is pending, so that data and the marker
  // never share a cycle. An empty buffer lets a fresh response go straight to
  // the output register, which gives a one-cycle response-to-output latency.
  assign out_allow = !next_stage_full && (state != S_EMIT);
  assign rb_empty  = (rb_count == '0);
  assign bypass    = out_allow && rb_empty && rsp_fwd;
  assign rb_push   = rsp_fwd && !bypass;
  assign rb_pop    = out_allow && !rb_empty;
  assign out_fire  = rb_pop || bypass;
  assign out_src   = rb_empty ? rsp_entry : rb_mem[rb_rd_ptr];

  assign ie_level = iteration_end && iteration_end_valid;
  // A vertex that arrives in the same cycle still belongs to this iteration.
  assign drained  = in_empty && !active_v_id_valid && (tag_count == '0)
                  && rb_empty && !out_valid;

  // ---------------------------------------------------------------------------
  // Iteration-end FSM
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first. A path that
  // skips an assignment would infer a latch.
  always_comb begin
    state_next = state;
    ie_pulse   = 1'b0;
    unique case (state)
      S_RUN:      if (ie_level) state_next = S_DRAIN;
      S_DRAIN:    if (drained) state_next = S_EMIT;
      S_EMIT: begin
        if (!next_stage_full) begin
          ie_pulse   = 1'b1;
          state_next = S_WAIT_CLR;
        end
      end
      // Wait for the held upstream level to drop before re-arming.
      S_WAIT_CLR: if (!ie_level) state_next = S_RUN;
      default:    state_next = S_RUN;
    endcase
  end

  assign out_iteration_end       = ie_pulse;
  assign out_iteration_end_valid = ie_pulse;

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, whatever the evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_RUN;
    else      state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Pointers, counters, flags and output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_wr_ptr   <= '0;
      in_rd_ptr   <= '0;
      in_count    <= '0;
      tag_wr_ptr  <= '0;
      tag_rd_ptr  <= '0;
      tag_count   <= '0;
      rb_wr_ptr   <= '0;
      rb_rd_ptr   <= '0;
      rb_count    <= '0;
      stage_full  <= 1'b1;
      overflow    <= 1'b0;
      out_valid   <= 1'b0;
      out_v_id    <= '0;
      out_loffset <= '0;
      out_roffset <= '0;
    end else begin
      if (in_push) in_wr_ptr <= in_wr_ptr + IN_AW'(1);
      if (in_pop)  in_rd_ptr <= in_rd_ptr + IN_AW'(1);
      in_count   <= in_count_next;
      stage_full <= (in_count_next >= IN_CW'(FIFO_DEPTH - FULL_MARGIN));
      if (active_v_id_valid && in_full) overflow <= 1'b1;

      if (in_pop)     tag_wr_ptr <= tag_wr_ptr + TAG_AW'(1);
      if (rsp_accept) tag_rd_ptr <= tag_rd_ptr + TAG_AW'(1);
      tag_count <= tag_count + TAG_CW'(in_pop) - TAG_CW'(rsp_accept);

      if (rb_push) rb_wr_ptr <= rb_wr_ptr + TAG_AW'(1);
      if (rb_pop)  rb_rd_ptr <= rb_rd_ptr + TAG_AW'(1);
      rb_count <= rb_count + TAG_CW'(rb_push) - TAG_CW'(rb_pop);

      out_valid <= out_fire;
      {out_v_id, out_loffset, out_roffset} <= out_fire ? out_src : '0;
    end
  end

  // NOTE: the storage arrays are not reset. The counters above qualify every
  // read, so stale contents are never used and the arrays can map to plain RAM.
  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr_ptr]   <= active_v_id;
    if (in_pop)  tag_mem[tag_wr_ptr] <= in_head;
    if (rb_push) rb_mem[rb_wr_ptr]   <= rsp_entry;
  end

  // ---------------------------------------------------------------------------
  // Simulation-only checks
  // ---------------------------------------------------------------------------
  overflow_never_set: assert property (@(posedge clk) disable iff (!rst) !overflow);

  rsp_buf_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(rb_push && !rb_pop && (rb_count == TAG_CW'(MAX_OUTSTANDING))));

  marker_excludes_data: assert property (@(posedge clk) disable iff (!rst)
    !(out_valid && out_iteration_end_valid));

endmodule

// File: tb/tb_active_vertex_offset_fetch.sv
// Directed bench for active_vertex_offset_fetch.
// A memory model answers offset reads in order after a fixed latency. The
// offsets are a function of the local index. Each vertex sent pushes its
// expected result to a scoreboard, and a monitor pops and compares every
// out_valid.
module tb_active_vertex_offset_fetch;

  localparam int VW  = 20;
  localparam int OW  = 24;
  localparam int LAT = 2;

  typedef struct packed {
    logic [VW-1:0] v_id;
    logic [OW-1:0] lo;
    logic [OW-1:0] ro;
  } exp_t;

  typedef struct {
    logic [VW-1:0] addr;
    int            due;
  } pend_t;

  logic          clk;
  logic          rst;
  logic [VW-1:0] active_v_id;
  logic          active_v_id_valid;
  logic          iteration_end;
  logic          iteration_end_valid;
  logic          stage_full;
  logic          next_stage_full;
  logic [VW-1:0] out_v_id;
  logic [OW-1:0] out_loffset;
  logic [OW-1:0] out_roffset;
  logic          out_valid;
  logic          out_iteration_end;
  logic          out_iteration_end_valid;

  active_vertex_offset_fetch_if #(.V_ID_WIDTH(VW), .OFFSET_WIDTH(OW)) mem_if ();

  active_vertex_offset_fetch dut (
    .clk                     (clk),
    .rst                     (rst),
    .active_v_id             (active_v_id),
    .active_v_id_valid       (active_v_id_valid),
    .iteration_end           (iteration_end),
    .iteration_end_valid     (iteration_end_valid),
    .stage_full              (stage_full),
    .mem                     (mem_if),
    .next_stage_full         (next_stage_full),
    .out_v_id                (out_v_id),
    .out_loffset             (out_loffset),
    .out_roffset             (out_roffset),
    .out_valid               (out_valid),
    .out_iteration_end       (out_iteration_end),
    .out_iteration_end_valid (out_iteration_end_valid)
  );

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  exp_t  exp_q[$];
  pend_t pend_q[$];
  logic  mem_ready = 1'b0;
  logic  mem_hold  = 1'b0;
  int    acc_cnt = 0;
  logic [VW-1:0] last_acc_addr = '0;
  int    last_rsp_cyc = -1;
  int    last_out_cyc = -1;
  int    out_cnt = 0;
  int    ie_cnt = 0;
  int    ie_cyc = -1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [OW-1:0] mem_lo(input logic [VW-1:0] a);
    return 24'h0C0 + OW'(a) * 24'h20;
  endfunction

  // Local index 10 models an isolated vertex (zero out-degree).
  function automatic logic [OW-1:0] mem_ro(input logic [VW-1:0] a);
    return (a == 20'd10) ? mem_lo(a) : mem_lo(a) + 24'h20;
  endfunction

  // Offset memory: in-order responses LAT cycles after acceptance.
  initial begin
    mem_if.offset_rd_ready  = 1'b0;
    mem_if.offset_rsp_valid = 1'b0;
    mem_if.offset_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!mem_hold && pend_q.size() > 0 && pend_q[0].due <= cyc + 1) begin
        pend_t p;
        p = pend_q.pop_front();
        mem_if.offset_rsp_valid = 1'b1;
        mem_if.offset_rsp_data  = {mem_ro(p.addr), mem_lo(p.addr)};
        last_rsp_cyc = cyc + 1;
      end else begin
        mem_if.offset_rsp_valid = 1'b0;
        mem_if.offset_rsp_data  = '0;
      end
      mem_if.offset_rd_ready = mem_ready;
      if (mem_if.offset_rd_valid && mem_ready) begin
        pend_t p;
        p.addr = mem_if.offset_rd_addr;
        p.due  = cyc + 1 + LAT;
        pend_q.push_back(p);
        acc_cnt++;
        last_acc_addr = mem_if.offset_rd_addr;
      end
    end
  end

  // Output monitor: scoreboard compare and iteration-end bookkeeping.
  initial forever begin
    @(negedge clk);
    if (out_valid) begin
      out_cnt++;
      last_out_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_out", {out_v_id, out_loffset, out_roffset}, 128'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", {out_v_id, out_loffset, out_roffset}, {e.v_id, e.lo, e.ro});
      end
    end
    if (out_iteration_end_valid) begin
      ie_cnt++;
      ie_cyc = cyc;
      check("ie_exclusive", {out_valid, out_iteration_end}, 2'b01);
    end
  end

  task automatic send_vtx(input logic [VW-1:0] v);
    int   n;
    exp_t e;
    n = 0;
    while (stage_full && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("send_timeout", 1, 0);
    active_v_id       = v;
    active_v_id_valid = 1'b1;
    e.v_id = v;
    e.lo   = mem_lo(v >> 5);
    e.ro   = mem_ro(v >> 5);
`ifdef ISOLATED_VTX_FILTER_EN
    if (e.lo != e.ro) exp_q.push_back(e);
`else
    exp_q.push_back(e);
`endif
    @(negedge clk);
    active_v_id_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    int acc0, oc0, ie0;
    rst                 = 1'b0;
    active_v_id         = '0;
    active_v_id_valid   = 1'b0;
    iteration_end       = 1'b0;
    iteration_end_valid = 1'b0;
    next_stage_full     = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_stage_full", stage_full, 1);
    check("rst_rd_valid", mem_if.offset_rd_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_ie_valid", out_iteration_end_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_stage_full", stage_full, 0);

    // 1: single vertex 0x45 -> addr 2, offsets 0x100/0x120
    mem_ready = 1'b1;
    @(negedge clk);
    send_vtx(20'h00045);
    wait_drain("t1_drain");
    check("t1_addr", last_acc_addr, 20'h2);
    check("t1_latency", last_out_cyc == last_rsp_cyc, 1);

    // 2: 20 vertices with memory stalled; stage_full at 12
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    acc0 = acc_cnt;
    for (int i = 0; i < 12; i++) begin
      check("t2_full_early", stage_full, 0);
      send_vtx(20'h00400 + VW'(i * 33));
    end
    check("t2_full_at_12", stage_full, 1);
    repeat (3) @(negedge clk);
    check("t2_full_held", stage_full, 1);
    check("t2_rd_valid_held", mem_if.offset_rd_valid, 1);
    check("t2_rd_addr_held", mem_if.offset_rd_addr, 20'h20);
    check("t2_no_accept", acc_cnt - acc0, 0);
    mem_ready = 1'b1;
    for (int i = 12; i < 20; i++) send_vtx(20'h00400 + VW'(i * 33));
    wait_drain("t2_drain");
    check("t2_accepts", acc_cnt - acc0, 20);

    // 3: downstream blocked -> at most 8 reads, then 8 back-to-back outputs
    next_stage_full = 1'b1;
    acc0 = acc_cnt;
    oc0  = out_cnt;
    for (int i = 0; i < 10; i++) send_vtx(20'h00803 + VW'(i * 32));
    repeat (30) @(negedge clk);
    check("t3_max_outstanding", acc_cnt - acc0, 8);
    check("t3_no_out", out_cnt - oc0, 0);
    check("t3_rd_valid_credit", mem_if.offset_rd_valid, 0);
    next_stage_full = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t3_consecutive", out_valid, 1);
    end
    wait_drain("t3_drain");
    check("t3_total", out_cnt - oc0, 10);

    // 5: isolated vertex (index 10, offsets 0x200/0x200) then a normal one
    oc0 = out_cnt;
    send_vtx(20'h00143);
    send_vtx(20'h00165);
    wait_drain("t5_drain");
    repeat (3) @(negedge clk);
`ifdef ISOLATED_VTX_FILTER_EN
    check("t5_out_count", out_cnt - oc0, 1);
`else
    check("t5_out_count", out_cnt - oc0, 2);
`endif

    // 4: iteration end held for 50 cycles after 3 vertices
    oc0 = out_cnt;
    ie0 = ie_cnt;
    send_vtx(20'h000A1);
    send_vtx(20'h000C2);
    send_vtx(20'h000E3);
    iteration_end       = 1'b1;
    iteration_end_valid = 1'b1;
    repeat (50) @(negedge clk);
    check("t4_outs", out_cnt - oc0, 3);
    check("t4_one_pulse", ie_cnt - ie0, 1);
    check("t4_after_last_out", ie_cyc > last_out_cyc, 1);
    iteration_end       = 1'b0;
    iteration_end_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("t4_no_retrigger", ie_cnt - ie0, 1);
    iteration_end       = 1'b1;
    iteration_end_valid = 1'b1;
    repeat (6) @(negedge clk);
    check("t4_second_pulse", ie_cnt - ie0, 2);
    iteration_end       = 1'b0;
    iteration_end_valid = 1'b0;
    repeat (3) @(negedge clk);

    // 6: async reset with 4 outstanding and 6 buffered
    mem_hold        = 1'b1;
    next_stage_full = 1'b1;
    acc0 = acc_cnt;
    for (int i = 0; i < 4; i++) send_vtx(20'h00300 + VW'(i * 32));
    repeat (4) @(negedge clk);
    check("t6_outstanding", acc_cnt - acc0, 4);
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 4; i < 10; i++) send_vtx(20'h00300 + VW'(i * 32));
    check("t6_pre_rd_valid", mem_if.offset_rd_valid, 1);
    #3 rst = 1'b0;
    #1;
    check("t6_stage_full", stage_full, 1);
    check("t6_rd_valid", mem_if.offset_rd_valid, 0);
    check("t6_rd_addr", mem_if.offset_rd_addr, 0);
    check("t6_out", {out_valid, out_v_id, out_loffset, out_roffset}, 0);
    check("t6_ie", {out_iteration_end, out_iteration_end_valid}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst             = 1'b1;
    next_stage_full = 1'b0;
    mem_ready       = 1'b1;
    mem_hold        = 1'b0;
    oc0 = out_cnt;
    repeat (10) @(negedge clk);
    check("t6_late_rsp_ignored", out_cnt - oc0, 0);
    send_vtx(20'h00021);
    wait_drain("t6_drain");
    check("t6_new_addr", last_acc_addr, 20'h1);
    check("t6_new_out", out_cnt - oc0, 1);

    repeat (5) @(negedge clk);
    check("final_scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
